// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
//   pc_state_t          : fetch FSM state encoding
//   PC_STEP             : sequential PC increment (one 32-bit instruction)
//   PC_ALIGN_MASK       : clears the low two bits of a redirect/trap target
//   NOP_INSTR_DEFAULT   : addi x0,x0,0, presented to decode when nothing is held
package pc_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } pc_state_t;

  localparam logic [31:0] PC_STEP           = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pc_adder.sv
// Plain 32-bit PC incrementer. Wraps modulo 2^32 with no carry out.
//   pc_i   : current PC
//   step_i : increment
//   sum_o  : pc_i + step_i
module pc_adder (
  input  logic [31:0] pc_i,
  input  logic [31:0] step_i,
  output logic [31:0] sum_o
);

  assign sum_o = pc_i + step_i;

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner and instruction-fetch sequencer for the RV32IM core.
// Keeps at most one instruction-memory request outstanding, steps the PC by 4
// on each delivered instruction, applies branch/jump redirects and trap
// vectors (trap wins), and hands the fetched word to decode over valid/ready.
//
// Build option: PC_MISALIGN_CHK_EN
//   defined   -> misaligned branch/jump targets are dropped and reported on
//                misalign_o / misalign_addr_o
//   undefined -> target low bits are silently cleared
//
// Ports
//   clk, rst                 core clock, async active-high reset
//   stall_i                  blocks issue of new fetch requests
//   redirect_valid_i/_pc_i   branch/jump taken and its target
//   trap_valid_i/trap_vec_i  trap entry and its vector
//   imem_req_o/imem_addr_o   fetch request and address (= pc_q)
//   imem_ready_i             memory accepts request
//   imem_rvalid_i/_rdata_i   fetch response
//   if_valid_o/_pc_o/_instr_o  instruction presented to decode
//   if_ready_i               decode accepts
//   misalign_o/_addr_o       (PC_MISALIGN_CHK_EN only) dropped misaligned redirect
//
// state  | meaning
// S_BOOT | first cycle out of reset, no request issued
// S_REQ  | request pc_q until memory accepts
// S_WAIT | request accepted, waiting for rvalid (kill_q marks it stale)
// S_HOLD | instruction held for decode until accepted or redirected
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_vec_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  input  logic        if_ready_i
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
`endif
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic        bad_align;
  logic        redir;
  logic [31:0] target;

`ifdef PC_MISALIGN_CHK_EN
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;

  // A trap is never blocked by this check; only a plain misaligned jump is.
  assign bad_align = redirect_valid_i & ~trap_valid_i & (redirect_pc_i[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  assign redir  = trap_valid_i | (redirect_valid_i & ~bad_align);
  assign target = (trap_valid_i ? trap_vec_i : redirect_pc_i) & PC_ALIGN_MASK;

  pc_adder u_pc_adder (
    .pc_i   (pc_q),
    .step_i (PC_STEP),
    .sum_o  (pc_plus4)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_BOOT;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  if (imem_req_o && imem_ready_i) state_d = S_WAIT;
      S_WAIT: if (imem_rvalid_i) state_d = (kill_q || redir) ? S_REQ : S_HOLD;
      S_HOLD: if (redir || if_ready_i) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req_o = (state_q == S_REQ) && !stall_i && !redir;
  end

  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;

  // Datapath next values
  always_comb begin
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (redir) pc_d = target;
    case (state_q)
      S_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (!kill_q && !redir) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata_i;
            pc_d       = pc_plus4;
          end
        end else if (redir) begin
          // Response still in flight: remember to drop it when it lands.
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir || if_ready_i) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
    end else begin
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  always_comb begin
    misalign_d      = bad_align;
    misalign_addr_d = bad_align ? redirect_pc_i : misalign_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0;
    end else begin
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
`endif

endmodule
